// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Latency 1 edge for captured fields; forwarding is same-cycle. stall holds, flush/load-use inject a bubble.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm_ext,
  input  logic [3:0]  id_alu_op,
  input  logic        id_alu_src,
  input  logic        id_shamt_sel,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic [4:0]  id_dst,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_dst,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_dst,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [3:0]  ex_alu_op,
  output logic [4:0]  ex_dst,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_alu_b,
  output logic [31:0] ex_store_data,
  output logic        load_use_hazard
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_op;
    logic [4:0]  dst;
    logic        alu_src;
    logic        shamt_sel;
    logic [31:0] inst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } ex_regs_t;

  ex_regs_t q;
  ex_regs_t d;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  assign id_rs = id_inst[25:21];
  assign id_rt = id_inst[20:16];
  assign ex_rs = q.inst[25:21];
  assign ex_rt = q.inst[20:16];

  // An empty decode slot still captures its datapath but never its side effects.
  always_comb begin
    d           = '0;
    d.valid     = id_valid;
    d.reg_write = id_valid & id_reg_write;
    d.mem_read  = id_valid & id_mem_read;
    d.mem_write = id_valid & id_mem_write;
    d.alu_op    = id_alu_op;
    d.dst       = id_dst;
    d.alu_src   = id_alu_src;
    d.shamt_sel = id_shamt_sel;
    d.inst      = id_inst;
    d.rs_data   = id_rs_data;
    d.rt_data   = id_rt_data;
    d.imm       = id_imm_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush || (!stall && load_use_hazard)) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

  // rt only matters to the hazard when it is read as a register (ALU B or store data).
  assign load_use_hazard = q.valid & q.mem_read & (q.dst != 5'd0) & id_valid &
                           ((q.dst == id_rs) |
                            ((q.dst == id_rt) & (!id_alu_src | id_mem_write)));

  // EX/MEM is younger than MEM/WB, so it is checked first.
  always_comb begin
    rs_fwd = q.rs_data;
    rt_fwd = q.rt_data;
    if (exmem_reg_write && (exmem_dst != 5'd0) && (exmem_dst == ex_rs)) begin
      rs_fwd = exmem_result;
    end else if (memwb_reg_write && (memwb_dst != 5'd0) && (memwb_dst == ex_rs)) begin
      rs_fwd = memwb_result;
    end
    if (exmem_reg_write && (exmem_dst != 5'd0) && (exmem_dst == ex_rt)) begin
      rt_fwd = exmem_result;
    end else if (memwb_reg_write && (memwb_dst != 5'd0) && (memwb_dst == ex_rt)) begin
      rt_fwd = memwb_result;
    end
  end

  assign ex_valid      = q.valid;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_alu_op     = q.alu_op;
  assign ex_dst        = q.dst;
  assign ex_alu_a      = q.shamt_sel ? q.inst : rs_fwd;
  assign ex_alu_b      = q.alu_src ? q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand sequences for stall, load-use and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_inst, id_rs_data, id_rt_data, id_imm_ext;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_shamt_sel, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  id_dst;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_dst, memwb_dst;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_dst;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
  logic        load_use_hazard;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_inst(id_inst), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm_ext(id_imm_ext), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_shamt_sel(id_shamt_sel), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_dst(id_dst), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op), .ex_dst(ex_dst),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  typedef struct {
    string       name;
    logic        vld;
    logic [31:0] inst, rs, rt, imm;
    logic [3:0]  op;
    logic        src, shs, rw, mw;
    logic [4:0]  dst;
    logic        flush;
    logic        xrw;
    logic [4:0]  xdst;
    logic [31:0] xres;
    logic        wrw;
    logic [4:0]  wdst;
    logic [31:0] wres;
    logic        e_vld, e_rw, e_mw;
    logic [3:0]  e_op;
    logic [4:0]  e_dst;
    logic [31:0] e_a, e_b, e_sd;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh);
    return {6'd0, rs, rt, 5'd0, sh, 6'd0};
  endfunction

  function automatic vec_t vec(
    input string n, input logic vld, input logic [31:0] inst, input logic [31:0] rs,
    input logic [31:0] rt, input logic [31:0] imm, input logic [3:0] op, input logic src,
    input logic shs, input logic rw, input logic mw, input logic [4:0] dst, input logic fl,
    input logic xrw, input logic [4:0] xdst, input logic [31:0] xres,
    input logic wrw, input logic [4:0] wdst, input logic [31:0] wres,
    input logic e_vld, input logic e_rw, input logic e_mw, input logic [3:0] e_op,
    input logic [4:0] e_dst, input logic [31:0] e_a, input logic [31:0] e_b, input logic [31:0] e_sd);
    vec_t v;
    v.name = n; v.vld = vld; v.inst = inst; v.rs = rs; v.rt = rt; v.imm = imm; v.op = op;
    v.src = src; v.shs = shs; v.rw = rw; v.mw = mw; v.dst = dst; v.flush = fl;
    v.xrw = xrw; v.xdst = xdst; v.xres = xres; v.wrw = wrw; v.wdst = wdst; v.wres = wres;
    v.e_vld = e_vld; v.e_rw = e_rw; v.e_mw = e_mw; v.e_op = e_op; v.e_dst = e_dst;
    v.e_a = e_a; v.e_b = e_b; v.e_sd = e_sd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic vld, input logic [31:0] inst, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] imm, input logic src,
                          input logic rw, input logic mr, input logic mw, input logic [4:0] dst);
    id_valid = vld; id_inst = inst; id_rs_data = rs; id_rt_data = rt; id_imm_ext = imm;
    id_alu_src = src; id_shamt_sel = 1'b0; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_dst = dst; id_alu_op = 4'h2;
  endtask

  task automatic fwd_off;
    exmem_reg_write = 1'b0; exmem_dst = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_dst = 5'd0; memwb_result = 32'h0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'h0);
    chk({tag, "_ctrl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'h0);
    chk({tag, "_op_dst"}, 32'({ex_alu_op, ex_dst}), 32'h0);
    chk({tag, "_a"}, ex_alu_a, 32'h0);
    chk({tag, "_b"}, ex_alu_b, 32'h0);
    chk({tag, "_sd"}, ex_store_data, 32'h0);
    chk({tag, "_luh"}, 32'(load_use_hazard), 32'h0);
  endtask

  initial begin
    tbl[0] = vec("add", 1, mk(1,2,0), 32'h100, 32'h200, 0, 4'h2, 0, 0, 1, 0, 5'd3, 0,
                 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'h2, 5'd3, 32'h100, 32'h200, 32'h200);
    tbl[1] = vec("sll_fwd", 1, mk(0,9,4), 0, 32'h99, 0, 4'h5, 0, 1, 1, 0, 5'd10, 0,
                 1, 5'd9, 32'hF0, 0, 0, 0, 1, 1, 0, 4'h5, 5'd10, mk(0,9,4), 32'hF0, 32'hF0);
    tbl[2] = vec("dual", 1, mk(5,6,0), 32'h55, 32'h66, 0, 4'h2, 0, 0, 1, 0, 5'd7, 0,
                 1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 1, 1, 0, 4'h2, 5'd7, 32'h11, 32'h66, 32'h66);
    tbl[3] = vec("dst0", 1, mk(0,0,0), 32'hAAAA, 32'hBBBB, 0, 4'h2, 0, 0, 1, 0, 5'd7, 0,
                 1, 5'd0, 32'h11, 1, 5'd0, 32'h22, 1, 1, 0, 4'h2, 5'd7, 32'hAAAA, 32'hBBBB, 32'hBBBB);
    tbl[4] = vec("store", 1, mk(4,3,0), 32'h44, 32'h33, 32'h10, 4'h1, 1, 0, 0, 1, 5'd0, 0,
                 0, 0, 0, 1, 5'd3, 32'hDEADBEEF, 1, 0, 1, 4'h1, 5'd0, 32'h44, 32'h10, 32'hDEADBEEF);
    tbl[5] = vec("memwb_rt", 1, mk(7,8,0), 32'h70, 32'h80, 0, 4'h2, 0, 0, 1, 0, 5'd2, 0,
                 0, 5'd7, 32'h77, 1, 5'd8, 32'h88, 1, 1, 0, 4'h2, 5'd2, 32'h70, 32'h88, 32'h88);
    tbl[6] = vec("invalid", 0, mk(1,2,0), 32'h10, 32'h20, 0, 4'h3, 0, 0, 1, 1, 5'd4, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h3, 5'd4, 32'h10, 32'h20, 32'h20);
    tbl[7] = vec("flush", 1, mk(1,2,0), 32'h10, 32'h20, 0, 4'h2, 0, 0, 1, 0, 5'd4, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0);

    // Power-on reset: outputs clear before any clock edge.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_off();
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      id_valid = tbl[i].vld; id_inst = tbl[i].inst; id_rs_data = tbl[i].rs;
      id_rt_data = tbl[i].rt; id_imm_ext = tbl[i].imm; id_alu_op = tbl[i].op;
      id_alu_src = tbl[i].src; id_shamt_sel = tbl[i].shs; id_reg_write = tbl[i].rw;
      id_mem_read = 1'b0; id_mem_write = tbl[i].mw; id_dst = tbl[i].dst;
      flush = tbl[i].flush; stall = 1'b0;
      exmem_reg_write = tbl[i].xrw; exmem_dst = tbl[i].xdst; exmem_result = tbl[i].xres;
      memwb_reg_write = tbl[i].wrw; memwb_dst = tbl[i].wdst; memwb_result = tbl[i].wres;
      tick();
      chk({tbl[i].name, "_valid"}, 32'(ex_valid), 32'(tbl[i].e_vld));
      chk({tbl[i].name, "_rw"}, 32'(ex_reg_write), 32'(tbl[i].e_rw));
      chk({tbl[i].name, "_mr"}, 32'(ex_mem_read), 32'h0);
      chk({tbl[i].name, "_mw"}, 32'(ex_mem_write), 32'(tbl[i].e_mw));
      chk({tbl[i].name, "_op"}, 32'(ex_alu_op), 32'(tbl[i].e_op));
      chk({tbl[i].name, "_dst"}, 32'(ex_dst), 32'(tbl[i].e_dst));
      chk({tbl[i].name, "_a"}, ex_alu_a, tbl[i].e_a);
      chk({tbl[i].name, "_b"}, ex_alu_b, tbl[i].e_b);
      chk({tbl[i].name, "_sd"}, ex_store_data, tbl[i].e_sd);
      chk({tbl[i].name, "_luh"}, 32'(load_use_hazard), 32'h0);
    end
    chk("sll_shamt_field", 32'(tbl[1].e_a[10:6]), 32'd4);
    flush = 1'b0;
    fwd_off();

    // stall and flush together: flush wins.
    drive_id(1, mk(1,2,0), 32'h123, 32'h456, 0, 0, 1, 0, 0, 5'd5);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk_zero("stall_flush");

    // Three stalled edges hold the captured instruction despite new ID contents.
    stall = 1'b0; flush = 1'b0;
    tick();
    chk("load_a", ex_alu_a, 32'h123);
    stall = 1'b1;
    drive_id(1, mk(3,4,0), 32'h999, 32'h888, 0, 0, 0, 0, 1, 5'd6);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_a", ex_alu_a, 32'h123);
      chk("stall_b", ex_alu_b, 32'h456);
      chk("stall_dst", 32'(ex_dst), 32'd5);
      chk("stall_ctrl", 32'({ex_valid, ex_reg_write, ex_mem_write}), 32'b110);
    end
    stall = 1'b0;

    // Load-use: lw $8 in EX, dependent instruction in ID.
    drive_id(1, mk(2,8,0), 32'h1000, 0, 32'h4, 1, 1, 1, 0, 5'd8);
    tick();
    chk("lw_mr", 32'(ex_mem_read), 32'h1);
    chk("lw_self_luh", 32'(load_use_hazard), 32'h0);
    drive_id(1, mk(1,8,0), 0, 0, 32'h8, 1, 0, 0, 1, 5'd0);
    #1 chk("sw_rt_luh", 32'(load_use_hazard), 32'h1);
    drive_id(1, mk(9,8,0), 0, 0, 32'h8, 1, 1, 0, 0, 5'd10);
    #1 chk("imm_rt_luh", 32'(load_use_hazard), 32'h0);
    drive_id(0, mk(8,1,0), 32'h5, 32'h6, 0, 0, 1, 0, 0, 5'd9);
    #1 chk("invalid_luh", 32'(load_use_hazard), 32'h0);
    id_valid = 1'b1;
    #1 chk("add_rs_luh", 32'(load_use_hazard), 32'h1);
    tick();
    chk("bubble_valid", 32'(ex_valid), 32'h0);
    chk("bubble_rw", 32'(ex_reg_write), 32'h0);
    chk("bubble_luh", 32'(load_use_hazard), 32'h0);
    tick();
    chk("replay_valid", 32'(ex_valid), 32'h1);
    chk("replay_dst", 32'(ex_dst), 32'd9);
    chk("replay_a", ex_alu_a, 32'h5);

    // Mid-cycle reset clears immediately and overrides stall/flush.
    #3;
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    #1 chk_zero("mid_reset");
    tick();
    chk_zero("held_reset");
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(1, mk(1,2,0), 32'h77, 32'h66, 0, 0, 1, 0, 0, 5'd12);
    tick();
    chk("post_reset_valid", 32'(ex_valid), 32'h1);
    chk("post_reset_a", ex_alu_a, 32'h77);
    chk("post_reset_dst", 32'(ex_dst), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be 32 bits and register indices 5 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_inst  in  32  decoded instruction word; rs=[25:21], rt=[20:16], shamt=[10:6].
REQ-006 id_rs_data, id_rt_data  in  32 each  register-file read values.
REQ-007 id_imm_ext  in  32  extended immediate.
REQ-008 id_alu_op  in  4  ALU operation code, passed through unchanged.
REQ-009 id_alu_src  in  1  1: ALU B = immediate; 0: ALU B = forwarded rt.
REQ-010 id_shamt_sel  in  1  1: shift-by-shamt op; ALU A = instruction word.
REQ-011 id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits; id_dst  in  5  write-back index.
REQ-012 stall  in  1  hold stage contents; flush  in  1  kill stage contents.
REQ-013 exmem_reg_write  in  1; exmem_dst  in  5; exmem_result  in  32  EX/MEM forwarding source.
REQ-014 memwb_reg_write  in  1; memwb_dst  in  5; memwb_result  in  32  MEM/WB forwarding source.
REQ-015 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered.
REQ-016 ex_alu_op  out  4  and ex_dst  out  5  registered.
REQ-017 ex_alu_a, ex_alu_b, ex_store_data  out  32 each  operands after forwarding.
REQ-018 load_use_hazard  out  1  combinational request to the hazard unit to freeze IF/ID.

Function
REQ-019 Per-edge update priority SHALL be: flush > stall > load_use_hazard > normal load.
REQ-020 flush SHALL load a bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; datapath registers don't-care but SHALL be zeroed.
REQ-021 stall (no flush) SHALL hold every register unchanged.
REQ-022 load_use_hazard=1 (no flush, no stall) SHALL load a bubble as in REQ-020.
REQ-023 Normal load SHALL capture all id_* inputs; if id_valid=0 the captured control bits SHALL be forced to 0 and ex_valid=0.
REQ-024 load_use_hazard SHALL be 1 iff ex_valid & ex_mem_read & ex_dst!=0 & id_valid & (ex_dst==id_inst[25:21] | (ex_dst==id_inst[20:16] & (!id_alu_src | id_mem_write))).
REQ-025 Forwarded rs: exmem_result if exmem_reg_write & exmem_dst!=0 & exmem_dst==registered rs; else memwb_result under the same test on MEM/WB; else registered rs data. Forwarded rt SHALL be selected identically.
REQ-026 EX/MEM SHALL win when both sources match; index 0 SHALL never be forwarded.
REQ-027 ex_alu_a = registered instruction word when shamt_sel=1 (shifter reads bits [10:6]), else forwarded rs.
REQ-028 ex_alu_b = registered immediate when alu_src=1, else forwarded rt; ex_store_data SHALL always be forwarded rt.
REQ-029 Latency: inputs captured at edge N SHALL appear on outputs after edge N; forwarding SHALL be combinational in the same cycle.

Reset
REQ-030 rst_n=0 SHALL immediately clear all registers, independent of clk: ex_valid=0, all control outputs 0, ex_alu_op=0, ex_dst=0, datapath registers 0.
REQ-031 While reset is asserted mid-operation, stall and flush SHALL be ignored; the first edge after release SHALL perform a normal load.

Verification
REQ-032 Reset: drive rst_n=0 between edges -> all ex_* outputs 0 before the next edge; load_use_hazard=0.
REQ-033 SLL forwarding: load sll rt=$9, shamt=4, shamt_sel=1; exmem_dst=9, exmem_result=0x0000_00F0, exmem_reg_write=1 -> ex_alu_a[10:6]=4, ex_alu_b=0x0000_00F0.
REQ-034 Dual match: exmem_dst=memwb_dst=5, results 0x11/0x22, registered rs=5 -> ex_alu_a=0x11; same with dst=0 -> registered rs data.
REQ-035 Load-use: EX holds lw $8 (ex_mem_read=1); ID holds add using rs=$8 -> load_use_hazard=1; next edge ex_valid=0, ex_reg_write=0.
REQ-036 Priority: stall=1 and flush=1 on one edge -> bubble; stall=1 alone for 3 edges -> outputs unchanged.
REQ-037 Store: sw with alu_src=1, rt=$3, memwb_dst=3, memwb_result=0xDEAD_BEEF -> ex_alu_b=immediate, ex_store_data=0xDEAD_BEEF.
